reg_scoreboard: RTL and testbench

- Sequential replacement for comparator-based ID stall detection in the 5-stage pipeline (ID/EX/MEM/WB).
- Keeps a per-architectural-register count of in-flight writers: increment when an rd-writing instruction leaves ID, decrement when it retires from WB.
- ID stalls while any enabled source register has a nonzero count.
- Also handles the ecall flush before WB and reports counter over/underflow.

---
 rtl/reg_scoreboard_pkg.sv | 30 +++
 rtl/reg_scoreboard_sb_reg_counter.sv | 55 +++++
 rtl/reg_scoreboard.sv | 122 ++++++++++++
 tb/tb_reg_scoreboard.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared types and constants for the register scoreboard.
//   REG_ADDR_W      : architectural register address width
//   SB_NUM_REGS     : number of architectural integer registers (x0 untracked)
//   SB_MAX_INFLIGHT : max simultaneous in-flight writers of one register
//   SB_CNT_W        : per-register counter width
//   sb_cnt_t        : per-register counter type
//   decoded_inst_t  : source-operand view of the instruction sitting in ID
package reg_scoreboard_pkg;

  localparam int REG_ADDR_W      = 5;
  localparam int SB_NUM_REGS     = 32;
  localparam int SB_MAX_INFLIGHT = 3;
  localparam int SB_CNT_W        = $clog2(SB_MAX_INFLIGHT + 1);

  typedef logic [SB_CNT_W-1:0] sb_cnt_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rs1;
    logic                  en_rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  en_rs2;
  } decoded_inst_t;

  // A source operand only matters when it is read and is not x0.
  function automatic logic src_live(input logic en, input logic [REG_ADDR_W-1:0] rs);
    return en && (rs != '0);
  endfunction

endpackage

// File: rtl/reg_scoreboard_sb_reg_counter.sv
// sb_reg_counter: in-flight writer count for one architectural register.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   inc          : a writer of this register leaves ID (already gated by flush)
//   dec          : a writer of this register retires from WB
//   flush_clr    : pipeline flush, counter is reloaded
//   flush_keep   : during flush, the surviving WB writer targets this register
//   count        : current count
//   nonzero      : count != 0
//   ovf, unf     : overflow / underflow event this cycle (not sticky)
module sb_reg_counter
  import reg_scoreboard_pkg::*;
#(
  parameter int MAX_INFLIGHT = SB_MAX_INFLIGHT,
  parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             flush_clr,
  input  logic             flush_keep,
  output logic [CNT_W-1:0] count,
  output logic             nonzero,
  output logic             ovf,
  output logic             unf
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic at_max;
  logic at_zero;

  assign at_max  = (count == CNT_MAX);
  assign at_zero = (count == '0);

  // Flush reloads the counter, so any inc/dec that cycle is not an error.
  assign ovf     = !flush_clr && inc && !dec && at_max;
  assign unf     = !flush_clr && dec && !inc && at_zero;
  assign nonzero = !at_zero;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (flush_clr) begin
      count <= flush_keep ? CNT_ONE : '0;
    end else if (inc && !dec) begin
      if (!at_max) count <= count + CNT_ONE;
    end else if (dec && !inc) begin
      if (!at_zero) count <= count - CNT_ONE;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register in-flight writer counts for ID RAW stalls.
// Optional build macro: SCOREBOARD_WB_BYPASS_EN -- when defined, a source
// whose only in-flight writer is retiring this cycle does not stall
// (write-first regfile makes the value visible in the same cycle).
// Ports:
//   clk, reset_n                       : clock, async active-low reset
//   id_valid, id_rs1/2, id_en_rs1/2    : instruction in ID and its sources
//   issue_fire, issue_en_rd, issue_rd  : ID -> EX advance and its destination
//   retire_fire, retire_rd             : WB register write commit
//   flush, wb_keep_valid, wb_keep_rd   : EX/MEM kill and surviving WB writer
//   id_stall                           : combinational RAW stall for ID
//   busy_vec                           : bit i set while register i has writers
//   sb_error                           : sticky counter over/underflow
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NUM_REGS     = SB_NUM_REGS,
  parameter int MAX_INFLIGHT = SB_MAX_INFLIGHT,
  parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic                  id_en_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_en_rs2,
  input  logic                  issue_fire,
  input  logic                  issue_en_rd,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  retire_fire,
  input  logic [REG_ADDR_W-1:0] retire_rd,
  input  logic                  flush,
  input  logic                  wb_keep_valid,
  input  logic [REG_ADDR_W-1:0] wb_keep_rd,
  output logic                  id_stall,
  output logic [NUM_REGS-1:0]   busy_vec,
  output logic                  sb_error
);

  decoded_inst_t id_inst;

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] nz;
  logic [NUM_REGS-1:0] ovf;
  logic [NUM_REGS-1:0] unf;

  assign id_inst = '{valid:  id_valid,
                     rs1:    id_rs1,
                     en_rs1: id_en_rs1,
                     rs2:    id_rs2,
                     en_rs2: id_en_rs2};

  // x0 is hardwired zero: no counter, never busy, never an error source.
  assign cnt[0] = '0;
  assign nz[0]  = 1'b0;
  assign ovf[0] = 1'b0;
  assign unf[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    localparam logic [REG_ADDR_W-1:0] RA = REG_ADDR_W'(r);

    logic inc;
    logic dec;
    logic keep;

    // An issue coinciding with flush is itself killed, so it never counts.
    assign inc  = issue_fire && issue_en_rd && (issue_rd == RA) && !flush;
    assign dec  = retire_fire && (retire_rd == RA);
    assign keep = wb_keep_valid && (wb_keep_rd == RA);

    sb_reg_counter #(
      .MAX_INFLIGHT (MAX_INFLIGHT),
      .CNT_W        (CNT_W)
    ) u_cnt (
      .clk        (clk),
      .reset_n    (reset_n),
      .inc        (inc),
      .dec        (dec),
      .flush_clr  (flush),
      .flush_keep (keep),
      .count      (cnt[r]),
      .nonzero    (nz[r]),
      .ovf        (ovf[r]),
      .unf        (unf[r])
    );
  end

  assign busy_vec = nz;

  logic [CNT_W-1:0] cnt_rs1;
  logic [CNT_W-1:0] cnt_rs2;
  logic             stall_rs1;
  logic             stall_rs2;

  assign cnt_rs1 = cnt[id_inst.rs1];
  assign cnt_rs2 = cnt[id_inst.rs2];

  always_comb begin
    stall_rs1 = src_live(id_inst.en_rs1, id_inst.rs1) && (cnt_rs1 != '0);
    stall_rs2 = src_live(id_inst.en_rs2, id_inst.rs2) && (cnt_rs2 != '0);
`ifdef SCOREBOARD_WB_BYPASS_EN
    // Only bypass when the retiring writer is the last one in flight;
    // with count > 1 a younger writer still owns the register.
    if (retire_fire && (retire_rd == id_inst.rs1) && (cnt_rs1 == CNT_W'(1)))
      stall_rs1 = 1'b0;
    if (retire_fire && (retire_rd == id_inst.rs2) && (cnt_rs2 == CNT_W'(1)))
      stall_rs2 = 1'b0;
`endif
  end

  assign id_stall = id_inst.valid && (stall_rs1 || stall_rs2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sb_error <= 1'b0;
    end else if ((|ovf) || (|unf)) begin
      sb_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

  logic        clk;
  logic        reset_n;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic        id_en_rs1;
  logic [4:0]  id_rs2;
  logic        id_en_rs2;
  logic        issue_fire;
  logic        issue_en_rd;
  logic [4:0]  issue_rd;
  logic        retire_fire;
  logic [4:0]  retire_rd;
  logic        flush;
  logic        wb_keep_valid;
  logic [4:0]  wb_keep_rd;
  logic        id_stall;
  logic [31:0] busy_vec;
  logic        sb_error;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  reg_scoreboard dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .id_valid      (id_valid),
    .id_rs1        (id_rs1),
    .id_en_rs1     (id_en_rs1),
    .id_rs2        (id_rs2),
    .id_en_rs2     (id_en_rs2),
    .issue_fire    (issue_fire),
    .issue_en_rd   (issue_en_rd),
    .issue_rd      (issue_rd),
    .retire_fire   (retire_fire),
    .retire_rd     (retire_rd),
    .flush         (flush),
    .wb_keep_valid (wb_keep_valid),
    .wb_keep_rd    (wb_keep_rd),
    .id_stall      (id_stall),
    .busy_vec      (busy_vec),
    .sb_error      (sb_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; outputs are read 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [4:0] rd, input int n);
    issue_fire = 1'b1; issue_en_rd = 1'b1; issue_rd = rd;
    repeat (n) tick();
    issue_fire = 1'b0; issue_en_rd = 1'b0; issue_rd = '0;
  endtask

  task automatic retire(input logic [4:0] rd, input int n);
    retire_fire = 1'b1; retire_rd = rd;
    repeat (n) tick();
    retire_fire = 1'b0; retire_rd = '0;
  endtask

  task automatic hard_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    reset_n = 1'b0;
    id_valid = 0; id_rs1 = 0; id_en_rs1 = 0; id_rs2 = 0; id_en_rs2 = 0;
    issue_fire = 0; issue_en_rd = 0; issue_rd = 0;
    retire_fire = 0; retire_rd = 0;
    flush = 0; wb_keep_valid = 0; wb_keep_rd = 0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    // Reset state
    check("rst_busy", busy_vec, 32'h0);
    check("rst_err", {31'b0, sb_error}, 32'h0);
    id_valid = 1; id_rs1 = 5; id_en_rs1 = 1;
    #1 check("rst_stall", {31'b0, id_stall}, 32'h0);
    id_valid = 0; id_rs1 = 0; id_en_rs1 = 0;

    // Underflow on x1, then two writers of x5, then async reset mid-operation
    retire(5'd1, 1);
    check("unf_err", {31'b0, sb_error}, 32'h1);
    check("unf_busy", busy_vec, 32'h0);
    issue(5'd5, 2);
    check("pre_rst_busy", busy_vec, 32'h0000_0020);
    reset_n = 1'b0;
    #1;
    check("async_rst_busy", busy_vec, 32'h0);
    check("async_rst_err", {31'b0, sb_error}, 32'h0);
    tick();
    reset_n = 1'b1;
    tick();

    // RAW stall and release on x5
    issue(5'd5, 1);
    id_valid = 1; id_rs1 = 5; id_en_rs1 = 1;
    #1 check("raw_stall", {31'b0, id_stall}, 32'h1);
    id_en_rs1 = 0;
    #1 check("raw_disabled", {31'b0, id_stall}, 32'h0);
    id_en_rs1 = 1;
    retire_fire = 1; retire_rd = 5;
`ifdef SCOREBOARD_WB_BYPASS_EN
    #1 check("raw_retire_cycle", {31'b0, id_stall}, 32'h0);
`else
    #1 check("raw_retire_cycle", {31'b0, id_stall}, 32'h1);
`endif
    tick();
    retire_fire = 0; retire_rd = 0;
    #1 check("raw_release", {31'b0, id_stall}, 32'h0);
    check("raw_busy", busy_vec, 32'h0);
    id_valid = 0; id_rs1 = 0; id_en_rs1 = 0;

    // Three writers of x7
    issue(5'd7, 3);
    check("mw_busy", busy_vec, 32'h0000_0080);
    check("mw_err", {31'b0, sb_error}, 32'h0);
    id_valid = 1; id_rs2 = 7; id_en_rs2 = 1;
    #1 check("mw_stall3", {31'b0, id_stall}, 32'h1);
    retire(5'd7, 1);
    #1 check("mw_stall2", {31'b0, id_stall}, 32'h1);
    retire(5'd7, 1);
    #1 check("mw_stall1", {31'b0, id_stall}, 32'h1);
    retire(5'd7, 1);
    #1 check("mw_clear", {31'b0, id_stall}, 32'h0);
    check("mw_busy_clear", busy_vec, 32'h0);
    check("mw_err_clear", {31'b0, sb_error}, 32'h0);
    id_valid = 0; id_rs2 = 0; id_en_rs2 = 0;

    // Fourth writer overflows: saturate at 3, sticky error
    issue(5'd7, 4);
    check("ovf_err", {31'b0, sb_error}, 32'h1);
    check("ovf_busy", busy_vec, 32'h0000_0080);
    retire(5'd7, 2);
    check("ovf_sat_busy", busy_vec, 32'h0000_0080);
    retire(5'd7, 1);
    check("ovf_sat_drain", busy_vec, 32'h0);
    check("ovf_sticky", {31'b0, sb_error}, 32'h1);
    hard_reset();

    // Simultaneous issue + retire of x9 with count 1
    issue(5'd9, 1);
    issue_fire = 1; issue_en_rd = 1; issue_rd = 9;
    retire_fire = 1; retire_rd = 9;
    tick();
    issue_fire = 0; issue_en_rd = 0; issue_rd = 0;
    retire_fire = 0; retire_rd = 0;
    check("sim_busy", busy_vec, 32'h0000_0200);
    check("sim_err", {31'b0, sb_error}, 32'h0);
    retire(5'd9, 1);
    check("sim_drain_busy", busy_vec, 32'h0);
    check("sim_drain_err", {31'b0, sb_error}, 32'h0);

    // Flush: x6 in WB survives, x4 (MEM) and x3 (EX) killed, x8 issue dropped
    issue(5'd6, 1);
    issue(5'd4, 1);
    issue(5'd3, 1);
    check("pre_flush_busy", busy_vec, 32'h0000_0058);
    flush = 1; wb_keep_valid = 1; wb_keep_rd = 6;
    issue_fire = 1; issue_en_rd = 1; issue_rd = 8;
    tick();
    flush = 0; wb_keep_valid = 0; wb_keep_rd = 0;
    issue_fire = 0; issue_en_rd = 0; issue_rd = 0;
    check("flush_busy", busy_vec, 32'h0000_0040);
    check("flush_err", {31'b0, sb_error}, 32'h0);
    retire(5'd6, 1);
    check("flush_keep_drain", busy_vec, 32'h0);
    check("flush_keep_err", {31'b0, sb_error}, 32'h0);

    // x0 writes are ignored
    issue(5'd0, 1);
    check("x0_issue_busy", busy_vec, 32'h0);
    retire(5'd0, 1);
    check("x0_retire_err", {31'b0, sb_error}, 32'h0);

    // Every tracked register busy; x0 and disabled sources never stall
    for (int r = 1; r < 32; r++) issue(5'(r), 1);
    check("all_busy", busy_vec, 32'hFFFF_FFFE);
    id_valid = 1; id_rs1 = 0; id_en_rs1 = 1; id_rs2 = 0; id_en_rs2 = 1;
    #1 check("x0_src_stall", {31'b0, id_stall}, 32'h0);
    id_rs1 = 3; id_en_rs1 = 0; id_rs2 = 9; id_en_rs2 = 0;
    #1 check("dis_src_stall", {31'b0, id_stall}, 32'h0);
    id_en_rs2 = 1;
    #1 check("rs2_only_stall", {31'b0, id_stall}, 32'h1);
    id_valid = 0;
    #1 check("invalid_stall", {31'b0, id_stall}, 32'h0);
    check("all_busy_err", {31'b0, sb_error}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
